// File: rtl/stage_e_md_pkg.sv
// rtl/stage_e_md_pkg.sv - shared op codes, forward selects and MD FSM states
package stage_e_md_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    MD_MUL   = 2'b00,
    MD_MULHU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle ALU (add, sub, and, or, signed slt)
module alu import stage_e_md_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      ctrl,
  output logic [XLEN-1:0] y
);
  alu_op_t op;
  assign op = alu_op_t'(ctrl);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/flopr.sv
// rtl/flopr.sv - register with synchronous active-high clear and load enable
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/md_iter.sv
// rtl/md_iter.sv - iterative unsigned multiply/divide, one bit per RUN cycle
module md_iter import stage_e_md_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            flush,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CNTW = $clog2(XLEN);

  md_state_t       state;
  logic [CNTW-1:0] cnt;
  logic [1:0]      op_q;
  logic [XLEN-1:0] acc, lo, opb;
  logic [XLEN:0]   mul_sum, div_sh;
  logic            div_ge, is_div;

  // acc:lo is the product (hi:lo) for multiply, remainder:quotient for divide
  always_comb begin
    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
    div_sh  = {acc, lo[XLEN-1]};
    div_ge  = div_sh >= {1'b0, opb};
    is_div  = (op_q == MD_DIVU) || (op_q == MD_REMU);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state <= MD_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      acc   <= '0;
      lo    <= '0;
      opb   <= '0;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          state <= MD_RUN;
          cnt   <= CNTW'(XLEN-1);
          op_q  <= op;
          acc   <= '0;
          lo    <= a;
          opb   <= b;
        end
        MD_RUN: begin
          if (is_div) begin
            // a zero divisor always "fits": quotient all-ones, remainder = dividend
            acc <= div_ge ? div_sh[XLEN-1:0] - opb : div_sh[XLEN-1:0];
            lo  <= {lo[XLEN-2:0], div_ge};
          end else begin
            acc <= mul_sum[XLEN:1];
            lo  <= {mul_sum[0], lo[XLEN-1:1]};
          end
          if (cnt == '0) state <= MD_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy   = start & (state != MD_DONE);
  assign done   = (state == MD_DONE);
  assign result = ((op_q == MD_MULHU) || (op_q == MD_REMU)) ? acc : lo;
endmodule

// File: rtl/mux2.sv
// rtl/mux2.sv - two-input selector
module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? d1 : d0;
endmodule

// File: rtl/mux3.sv
// rtl/mux3.sv - three-input forwarding selector
module mux3 import stage_e_md_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = d2;
    case (s)
      FWD_REG: y = d0;
      FWD_WB:  y = d1;
      default: y = d2;
    endcase
  end
endmodule

// File: rtl/stage_e_md.sv
// rtl/stage_e_md.sv - execute stage with forwarding, ALU and iterative MD unit
module stage_e_md import stage_e_md_pkg::*; #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] Rd1D,
  input  logic [XLEN-1:0] Rd2D,
  input  logic [XLEN-1:0] immextD,
  input  logic [REGW-1:0] RdD,
  input  logic [REGW-1:0] Rs1D,
  input  logic [REGW-1:0] Rs2D,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            ALUSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic            MDD,
  input  logic [1:0]      MDOpD,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [REGW-1:0] RdE,
  output logic [REGW-1:0] Rs1E,
  output logic [REGW-1:0] Rs2E,
  output logic [XLEN-1:0] ALUResultE,
  output logic [XLEN-1:0] WriteDataE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            MDBusyE
);
  localparam int EW = 3*XLEN + 3*REGW + 9;

  logic [EW-1:0]   e_d, e_q;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_e, op1_e, op2_e, alu_y, md_y;
  logic            reg_write_e, mem_write_e, alu_src_e, md_e, md_done, clr_e;
  logic [2:0]      alu_ctrl_e;
  logic [1:0]      md_op_e;

  assign clr_e = rst | FlushE;
  assign e_d   = {Rd1D, Rd2D, immextD, RdD, Rs1D, Rs2D,
                  RegWriteD, MemWriteD, ALUSrcD, ALUControlD, MDD, MDOpD};
  assign {rd1_e, rd2_e, imm_e, RdE, Rs1E, Rs2E,
          reg_write_e, mem_write_e, alu_src_e, alu_ctrl_e, md_e, md_op_e} = e_q;

  // E holds its instruction while the MD unit is iterating
  flopr #(.WIDTH(EW)) e_reg (
    .clk(clk), .rst(clr_e), .en(~MDBusyE), .d(e_d), .q(e_q)
  );

  mux3 #(.WIDTH(XLEN)) fwd_a (
    .d0(rd1_e), .d1(ResultW), .d2(ALUResultM), .s(ForwardAE), .y(op1_e)
  );
  mux3 #(.WIDTH(XLEN)) fwd_b (
    .d0(rd2_e), .d1(ResultW), .d2(ALUResultM), .s(ForwardBE), .y(WriteDataE)
  );
  mux2 #(.WIDTH(XLEN)) src_b (
    .d0(WriteDataE), .d1(imm_e), .s(alu_src_e), .y(op2_e)
  );

  alu #(.XLEN(XLEN)) u_alu (
    .a(op1_e), .b(op2_e), .ctrl(alu_ctrl_e), .y(alu_y)
  );

  md_iter #(.XLEN(XLEN)) u_md (
    .clk(clk), .flush(clr_e), .start(md_e), .op(md_op_e),
    .a(op1_e), .b(op2_e), .busy(MDBusyE), .done(md_done), .result(md_y)
  );

  mux2 #(.WIDTH(XLEN)) res_mux (
    .d0(alu_y), .d1(md_y), .s(md_done), .y(ALUResultE)
  );

  assign RegWriteE = reg_write_e & ~MDBusyE;
  assign MemWriteE = mem_write_e & ~MDBusyE;
endmodule

// File: tb/tb_stage_e_md.sv
// tb/tb_stage_e_md.sv - directed self-checking bench for stage_e_md
module tb_stage_e_md;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] Rd1D, Rd2D, immextD, ALUResultM, ResultW;
  logic [REGW-1:0] RdD, Rs1D, Rs2D;
  logic            RegWriteD, MemWriteD, ALUSrcD, MDD, FlushE;
  logic [2:0]      ALUControlD;
  logic [1:0]      MDOpD, ForwardAE, ForwardBE;
  logic [REGW-1:0] RdE, Rs1E, Rs2E;
  logic [XLEN-1:0] ALUResultE, WriteDataE;
  logic            RegWriteE, MemWriteE, MDBusyE;

  int n_cmp = 0;
  int n_bad = 0;

  stage_e_md #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst(rst),
    .Rd1D(Rd1D), .Rd2D(Rd2D), .immextD(immextD),
    .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .MDD(MDD), .MDOpD(MDOpD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .FlushE(FlushE),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MDBusyE(MDBusyE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [2:0] ctrl, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    MDD = 1'b0; MDOpD = 2'b00; ALUControlD = ctrl;
    Rd1D = a; Rd2D = b; ALUSrcD = 1'b0; immextD = '0;
    RegWriteD = 1'b1; MemWriteD = 1'b0; RdD = 5'd4; Rs1D = 5'd1; Rs2D = 5'd2;
  endtask

  // issue one MD op; the follow-on add 1+2 waits in D until the unit finishes
  task automatic run_md(input string tag, input logic [1:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp);
    int   busy_n;
    logic leak;
    set_alu(3'b000, a, b);
    MDD = 1'b1; MDOpD = op; RdD = 5'd9;
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    tick;
    set_alu(3'b000, 32'd1, 32'd2);
    busy_n = 0;
    leak   = 1'b0;
    while (MDBusyE && busy_n < 100) begin
      busy_n++;
      leak = leak | RegWriteE | MemWriteE;
      tick;
      if (busy_n == 1) begin
        ForwardAE = 2'b10; ForwardBE = 2'b01;
        ALUResultM = 32'hDEAD_BEEF; ResultW = 32'h1234_5678;
      end
    end
    check({tag, "_busy_cycles"}, busy_n, 32'd33);
    check({tag, "_result"}, ALUResultE, exp);
    check({tag, "_regwrite"}, {31'd0, RegWriteE}, 32'd1);
    check({tag, "_rde"}, {27'd0, RdE}, 32'd9);
    check({tag, "_bubble"}, {31'd0, leak}, 32'd0);
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    tick;
    check({tag, "_next"}, ALUResultE, 32'd3);
  endtask

  logic [2:0]      v_ctrl [6];
  logic [XLEN-1:0] v_a    [6];
  logic [XLEN-1:0] v_b    [6];
  logic [XLEN-1:0] v_exp  [6];

  initial begin
    v_ctrl[0] = 3'b000; v_a[0] = 32'd5;         v_b[0] = 32'd3;         v_exp[0] = 32'd8;
    v_ctrl[1] = 3'b001; v_a[1] = 32'd3;         v_b[1] = 32'd5;         v_exp[1] = 32'hFFFF_FFFE;
    v_ctrl[2] = 3'b010; v_a[2] = 32'h0000_F0F0; v_b[2] = 32'h0000_FF00; v_exp[2] = 32'h0000_F000;
    v_ctrl[3] = 3'b011; v_a[3] = 32'h0000_F0F0; v_b[3] = 32'h0000_FF00; v_exp[3] = 32'h0000_FFF0;
    v_ctrl[4] = 3'b101; v_a[4] = 32'hFFFF_FFFF; v_b[4] = 32'd1;         v_exp[4] = 32'd1;
    v_ctrl[5] = 3'b101; v_a[5] = 32'd1;         v_b[5] = 32'hFFFF_FFFF; v_exp[5] = 32'd0;

    // reset with busy-looking D inputs: E must still come up all-zero
    rst = 1'b1; FlushE = 1'b0;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ALUResultM = '0; ResultW = '0;
    set_alu(3'b000, 32'd5, 32'd3);
    MemWriteD = 1'b1; MDD = 1'b1; RdD = 5'd7;
    tick; tick;
    check("rst_rde",      {27'd0, RdE},  32'd0);
    check("rst_rs1e",     {27'd0, Rs1E}, 32'd0);
    check("rst_rs2e",     {27'd0, Rs2E}, 32'd0);
    check("rst_regwrite", {31'd0, RegWriteE}, 32'd0);
    check("rst_memwrite", {31'd0, MemWriteE}, 32'd0);
    check("rst_busy",     {31'd0, MDBusyE},   32'd0);
    check("rst_result",   ALUResultE, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      set_alu(v_ctrl[i], v_a[i], v_b[i]);
      RdD = 5'd7;
      tick;
      check($sformatf("alu_%0d", i), ALUResultE, v_exp[i]);
      check($sformatf("alu_%0d_busy", i), {31'd0, MDBusyE}, 32'd0);
    end
    check("alu_rde", {27'd0, RdE}, 32'd7);

    set_alu(3'b001, 32'h99, 32'd1);
    ForwardAE = 2'b10; ALUResultM = 32'h10;
    tick;
    check("fwd_mem_sub", ALUResultE, 32'hF);
    ForwardAE = 2'b00;

    set_alu(3'b000, 32'h10, 32'h20);
    MemWriteD = 1'b1;
    ForwardBE = 2'b01; ResultW = 32'h55;
    tick;
    check("fwd_wb_store", WriteDataE, 32'h55);
    check("fwd_wb_add",   ALUResultE, 32'h65);
    check("store_memwrite", {31'd0, MemWriteE}, 32'd1);
    ForwardBE = 2'b00;

    set_alu(3'b000, 32'h10, 32'h20);
    ALUSrcD = 1'b1; immextD = 32'h100;
    tick;
    check("imm_add",   ALUResultE, 32'h110);
    check("imm_wdata", WriteDataE, 32'h20);

    run_md("mul",       2'b00, 32'd7,         32'd6,         32'd42);
    run_md("mul_wrap",  2'b00, 32'h0001_0000, 32'h0001_0000, 32'd0);
    run_md("mulhu",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("divu",      2'b10, 32'd100,       32'd7,         32'd14);
    run_md("remu",      2'b11, 32'd100,       32'd7,         32'd2);
    run_md("divu_zero", 2'b10, 32'd9,         32'd0,         32'hFFFF_FFFF);
    run_md("remu_zero", 2'b11, 32'd9,         32'd0,         32'd9);

    // FlushE mid-RUN
    set_alu(3'b000, 32'd7, 32'd6);
    MDD = 1'b1; MDOpD = 2'b00; RdD = 5'd9;
    tick;
    repeat (10) tick;
    check("flush_pre_busy", {31'd0, MDBusyE}, 32'd1);
    set_alu(3'b000, 32'd1, 32'd2);
    FlushE = 1'b1;
    tick;
    FlushE = 1'b0;
    check("flush_busy",     {31'd0, MDBusyE},   32'd0);
    check("flush_regwrite", {31'd0, RegWriteE}, 32'd0);
    check("flush_result",   ALUResultE, 32'd0);
    tick;
    check("flush_next", ALUResultE, 32'd3);
    check("flush_next_busy", {31'd0, MDBusyE}, 32'd0);

    // rst mid-RUN
    set_alu(3'b000, 32'd100, 32'd7);
    MDD = 1'b1; MDOpD = 2'b10; RdD = 5'd9;
    tick;
    repeat (10) tick;
    check("rstrun_pre_busy", {31'd0, MDBusyE}, 32'd1);
    set_alu(3'b000, 32'd1, 32'd2);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rstrun_busy",     {31'd0, MDBusyE},   32'd0);
    check("rstrun_regwrite", {31'd0, RegWriteE}, 32'd0);
    check("rstrun_result",   ALUResultE, 32'd0);
    tick;
    check("rstrun_next", ALUResultE, 32'd3);

    // restarted MD after abort must run full latency from scratch
    run_md("mul_after_abort", 2'b00, 32'd7, 32'd6, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
